// File: rtl/branch_predict_unit_pkg.sv
// Shared constants and helpers for the branch prediction unit.
// Decode constants, BHT reset value and the 2-bit saturating counter update.
package bpu_pkg;

   localparam logic [2:0] OPC_JMP  = 3'b100;
   localparam int         JUMP_BIT = 13;
   localparam logic [1:0] BHT_INIT = 2'b01;

   // Saturating 2-bit counter: +1 on taken (max 3), -1 on not-taken (min 0).
   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      if (taken) begin
         res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
      end else begin
         res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
      end
      return res;
   endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch/resolve bus of the branch prediction unit.
// master: fetch + execute stages; slave: the predictor.
interface branch_predict_unit_if #(
   parameter int IW = 22,
   parameter int AW = 11
);
   logic          i_valid;
   logic [IW-1:0] I;
   logic [AW-1:0] PC;
   logic          enable;
   logic          pred_taken;
   logic [AW-1:0] next;
   logic          stall;
   logic          res_valid;
   logic          res_taken;
   logic          mispredict;
   logic [AW-1:0] redirect;
   logic          res_err;

   modport master (
      output i_valid, I, PC, res_valid, res_taken,
      input  enable, pred_taken, next, stall, mispredict, redirect, res_err
   );

   modport slave (
      input  i_valid, I, PC, res_valid, res_taken,
      output enable, pred_taken, next, stall, mispredict, redirect, res_err
   );
endinterface

// File: rtl/branch_predict_unit_queue.sv
// bpu_queue: in-order FIFO of outstanding predictions with a flush input.
// Flush wins over push and makes the queue empty (read pointer jumps to the
// pre-edge write pointer, so a same-cycle push is dropped).
module bpu_queue #(
   parameter int W    = 23,
   parameter int QD_W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         empty_o,
   output logic         full_o
);
   localparam int DEPTH = 1 << QD_W;
   localparam logic [QD_W:0] PTR_ONE = {{QD_W{1'b0}}, 1'b1};

   logic [W-1:0]  mem_q [DEPTH];
   logic [QD_W:0] wr_q, wr_d, rd_q, rd_d;
   logic          push_ok;

   assign empty_o = (rd_q == wr_q);
   assign full_o  = (rd_q[QD_W] != wr_q[QD_W]) && (rd_q[QD_W-1:0] == wr_q[QD_W-1:0]);
   assign rdata_o = mem_q[rd_q[QD_W-1:0]];
   // A push into a full queue is only legal when the head leaves the same cycle.
   assign push_ok = push_i & (~full_o | pop_i);

   // Next-state pointers: flush discards everything, else independent push/pop.
   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (flush_i) begin
         rd_d = wr_q;
      end else begin
         if (push_ok) begin
            wr_d = wr_q + PTR_ONE;
         end else begin
            wr_d = wr_q;
         end
         if (pop_i && !empty_o) begin
            rd_d = rd_q + PTR_ONE;
         end else begin
            rd_d = rd_q;
         end
      end
   end

   // Pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage; contents are don't-care after reset so it carries no reset.
   always_ff @(posedge clk) begin
      if (push_ok && !flush_i) begin
         mem_q[wr_q[QD_W-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: fetch-stage branch decode, 2-bit BHT prediction,
// outstanding-prediction queue and misprediction redirect on resolve.
// Optional BPU_STATS_EN adds saturating stat_pred / stat_miss counters.
module branch_predict_unit
   import bpu_pkg::*;
#(
   parameter int IW    = 22,
   parameter int AW    = 11,
   parameter int IDX_W = 4,
   parameter int QD_W  = 2
) (
   input  logic clk,
   input  logic rst,
   branch_predict_unit_if.slave bus
`ifdef BPU_STATS_EN
   ,
   output logic [15:0] stat_pred,
   output logic [15:0] stat_miss
`endif
);
   localparam int EW = 2 * AW + 1;

   logic [1:0]    bht_q [1 << IDX_W];
   logic          jump, uncond, cond;
   logic [AW-1:0] target;
   logic [1:0]    bht_rd;
   logic          q_full, q_empty;
   logic [EW-1:0] head;
   logic [AW-1:0] head_pc, head_tgt;
   logic          head_pred;
   logic          resolve, miss;
   logic          mispredict_q, mispredict_d, res_err_q, res_err_d;
   logic [AW-1:0] redirect_q, redirect_d;

   assign jump   = bus.I[JUMP_BIT];
   assign uncond = (bus.I[JUMP_BIT:JUMP_BIT-2] == OPC_JMP);
   assign cond   = jump & ~uncond;
   assign target = bus.I[AW-1:0];
   assign bht_rd = bht_q[bus.PC[IDX_W-1:0]];

   assign bus.pred_taken = cond & bus.i_valid & bht_rd[1];
   assign bus.stall      = cond & bus.i_valid & q_full;
   assign bus.enable     = cond & bus.i_valid & ~q_full;

   // Predicted next fetch address.
   always_comb begin
      if (!jump) begin
         bus.next = bus.PC;
      end else if (uncond) begin
         bus.next = target;
      end else begin
         bus.next = bus.pred_taken ? target : bus.PC;
      end
   end

   bpu_queue #(.W(EW), .QD_W(QD_W)) u_queue (
      .clk     (clk),
      .rst     (rst),
      .push_i  (bus.enable),
      .pop_i   (resolve),
      .flush_i (miss),
      .wdata_i ({bus.PC, target, bus.pred_taken}),
      .rdata_o (head),
      .empty_o (q_empty),
      .full_o  (q_full)
   );

   assign head_pc   = head[EW-1:AW+1];
   assign head_tgt  = head[AW:1];
   assign head_pred = head[0];
   assign resolve   = bus.res_valid & ~q_empty;
   assign miss      = resolve & (bus.res_taken != head_pred);

   // Next values of the registered resolve outputs.
   always_comb begin
      mispredict_d = miss;
      res_err_d    = bus.res_valid & q_empty;
      if (miss) begin
         redirect_d = bus.res_taken ? head_tgt : head_pc;
      end else begin
         redirect_d = redirect_q;
      end
   end

   // Resolve output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mispredict_q <= 1'b0;
         res_err_q    <= 1'b0;
         redirect_q   <= '0;
      end else begin
         mispredict_q <= mispredict_d;
         res_err_q    <= res_err_d;
         redirect_q   <= redirect_d;
      end
   end

   assign bus.mispredict = mispredict_q;
   assign bus.res_err    = res_err_q;
   assign bus.redirect   = redirect_q;

   // BHT training on every resolved branch; lookups this cycle see old values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < (1 << IDX_W); i++) begin
            bht_q[i] <= BHT_INIT;
         end
      end else if (resolve) begin
         bht_q[head_pc[IDX_W-1:0]] <= sat_update(bht_q[head_pc[IDX_W-1:0]], bus.res_taken);
      end
   end

`ifdef BPU_STATS_EN
   logic [15:0] stat_pred_q, stat_miss_q;

   // Saturating resolve and mispredict counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_pred_q <= 16'h0000;
         stat_miss_q <= 16'h0000;
      end else begin
         if (resolve && stat_pred_q != 16'hFFFF) begin
            stat_pred_q <= stat_pred_q + 16'h0001;
         end
         if (miss && stat_miss_q != 16'hFFFF) begin
            stat_miss_q <= stat_miss_q + 16'h0001;
         end
      end
   end

   assign stat_pred = stat_pred_q;
   assign stat_miss = stat_miss_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_branch_predict_unit;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   branch_predict_unit_if #(.IW(22), .AW(11)) bus ();

`ifdef BPU_STATS_EN
   logic [15:0] stat_pred, stat_miss;
`endif

   branch_predict_unit #(.IW(22), .AW(11), .IDX_W(4), .QD_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus)
`ifdef BPU_STATS_EN
      ,
      .stat_pred (stat_pred),
      .stat_miss (stat_miss)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a conditional branch (JZE encoding) at pc with target 0x100+pc.
   task automatic put_cond(input logic [10:0] pc);
      bus.i_valid = 1'b1;
      bus.PC      = pc;
      bus.I       = {8'h00, 3'b101, 11'h100 + pc};
   endtask

   task automatic idle();
      bus.i_valid   = 1'b0;
      bus.I         = 22'h000000;
      bus.PC        = 11'h000;
      bus.res_valid = 1'b0;
      bus.res_taken = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_mispredict", bus.mispredict, 1'b0);
      chk("rst_redirect", bus.redirect, 11'h000);
      chk("rst_res_err", bus.res_err, 1'b0);

      // Non-jump
      bus.i_valid = 1'b1; bus.PC = 11'h005; bus.I = {8'h00, 3'b000, 11'h7FF};
      #1;
      chk("nojump_next", bus.next, 11'h005);
      chk("nojump_enable", bus.enable, 1'b0);
      chk("nojump_pred", bus.pred_taken, 1'b0);

      // Unconditional jump: redirect to target, nothing queued
      bus.I = {8'h00, 3'b100, 11'h123};
      #1;
      chk("uncond_next", bus.next, 11'h123);
      chk("uncond_enable", bus.enable, 1'b0);
      tick();
      idle();
      bus.res_valid = 1'b1;
      tick();
      chk("uncond_nopush_res_err", bus.res_err, 1'b1);
      idle();
      tick();
      chk("res_err_pulse_clear", bus.res_err, 1'b0);

      // Conditional at 0x010, target 0x200, BHT weakly not-taken
      bus.i_valid = 1'b1; bus.PC = 11'h010; bus.I = {8'h00, 3'b101, 11'h200};
      #1;
      chk("cond1_enable", bus.enable, 1'b1);
      chk("cond1_pred", bus.pred_taken, 1'b0);
      chk("cond1_next", bus.next, 11'h010);
      tick();
      idle();
      bus.res_valid = 1'b1; bus.res_taken = 1'b1;
      tick();
      chk("cond1_mispredict", bus.mispredict, 1'b1);
      chk("cond1_redirect", bus.redirect, 11'h200);
      idle();
      tick();
      chk("mispredict_pulse_clear", bus.mispredict, 1'b0);

      // Repeat: BHT[0] now 10 -> predicted taken
      bus.i_valid = 1'b1; bus.PC = 11'h010; bus.I = {8'h00, 3'b101, 11'h200};
      #1;
      chk("cond2_pred", bus.pred_taken, 1'b1);
      chk("cond2_next", bus.next, 11'h200);
      chk("cond2_enable", bus.enable, 1'b1);
      tick();
      idle();
      bus.res_valid = 1'b1; bus.res_taken = 1'b1;
      tick();
      chk("cond2_correct", bus.mispredict, 1'b0);
      idle();

      // Fill the queue with PCs 1..4
      for (int p = 1; p <= 4; p++) begin
         put_cond(11'(p));
         #1;
         chk("fill_enable", bus.enable, 1'b1);
         tick();
      end
      put_cond(11'h005);
      #1;
      chk("full_stall", bus.stall, 1'b1);
      chk("full_enable", bus.enable, 1'b0);
      tick();
      chk("full_stall_hold", bus.stall, 1'b1);
      // Correct resolve of PC1 while full; stall holds this cycle
      bus.res_valid = 1'b1; bus.res_taken = 1'b0;
      #1;
      chk("full_pop_stall_same_cycle", bus.stall, 1'b1);
      tick();
      bus.res_valid = 1'b0;
      #1;
      chk("stall_cleared", bus.stall, 1'b0);
      chk("stall_cleared_enable", bus.enable, 1'b1);
      chk("resolve_pc1_correct", bus.mispredict, 1'b0);
      tick();                                   // push PC5: queue 2,3,4,5
      idle();
      bus.res_valid = 1'b1; bus.res_taken = 1'b0;
      tick();                                   // pop PC2: queue 3,4,5
      // Mispredict PC3 with a same-cycle push of PC6
      put_cond(11'h006);
      bus.res_valid = 1'b1; bus.res_taken = 1'b1;
      #1;
      chk("flush_push_enable", bus.enable, 1'b1);
      tick();
      chk("flush_mispredict", bus.mispredict, 1'b1);
      chk("flush_redirect", bus.redirect, 11'h103);
      idle();
      bus.res_valid = 1'b1; bus.res_taken = 1'b1;
      tick();
      chk("flush_empty_res_err", bus.res_err, 1'b1);
      chk("flush_mispredict_clear", bus.mispredict, 1'b0);
      idle();
      put_cond(11'h003);
      #1;
      chk("bht3_trained", bus.pred_taken, 1'b1);
      chk("bht3_next", bus.next, 11'h103);
      put_cond(11'h006);
      #1;
      chk("bht6_untouched", bus.pred_taken, 1'b0);
      idle();
      tick();

      // Reset mid-queue with BHT[0] = 11
      bus.i_valid = 1'b1; bus.PC = 11'h020; bus.I = {8'h00, 3'b101, 11'h220};
      #1;
      chk("bht0_strong", bus.pred_taken, 1'b1);
      tick();
      put_cond(11'h021);
      tick();
      idle();
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_mispredict", bus.mispredict, 1'b0);
      chk("midrst_redirect", bus.redirect, 11'h000);
      chk("midrst_res_err", bus.res_err, 1'b0);
      tick();
      rst = 1'b0;
      bus.i_valid = 1'b1; bus.PC = 11'h010; bus.I = {8'h00, 3'b101, 11'h200};
      #1;
      chk("midrst_bht0_init", bus.pred_taken, 1'b0);
      chk("midrst_next", bus.next, 11'h010);
      chk("midrst_no_stall", bus.stall, 1'b0);
      idle();
      bus.res_valid = 1'b1;
      tick();
      chk("midrst_queue_empty", bus.res_err, 1'b1);
      idle();
      tick();

`ifdef BPU_STATS_EN
      for (int p = 1; p <= 3; p++) begin
         put_cond(11'(p));
         tick();
      end
      idle();
      bus.res_valid = 1'b1; bus.res_taken = 1'b0;
      tick();
      tick();
      bus.res_taken = 1'b1;
      tick();
      idle();
      #1;
      chk("stat_pred", 32'(stat_pred), 32'd3);
      chk("stat_miss", 32'(stat_miss), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the fetch-stage prediction control.
- Adds a 2-bit saturating-counter branch history table (BHT) indexed by low PC bits.
- Adds an in-order queue of outstanding conditional-branch predictions, and misprediction detection with redirect on resolution.
- Sits between instruction RAM output and the PC mux; the execute stage drives the resolve port.

Parameters:
- IW, 22, instruction width
- AW, 11, PC / target address width
- IDX_W, 4, BHT index bits (2^IDX_W entries)
- QD_W, 2, log2 of outstanding-prediction queue depth (4 entries)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_valid  in  1  I/PC valid this cycle
- I  in  IW  fetched instruction
- PC  in  AW  current PC
- enable  out  1  I is a conditional jump (JZE/JNE/JCY) and a prediction was made
- pred_taken  out  1  predicted direction; 0 unless enable
- next  out  AW  predicted next fetch address
- stall  out  1  conditional branch fetched while queue full; no push
- res_valid  in  1  oldest outstanding branch resolved
- res_taken  in  1  actual direction
- mispredict  out  1  one-cycle pulse, registered
- redirect  out  AW  correct fetch address, valid while mispredict=1
- res_err  out  1  one-cycle pulse: res_valid while queue empty

Behaviour:
- Decode (combinational):
  - jump = I[13]; uncond = (I[13:11] == 3'b100); cond = jump & ~uncond.
  - Target = I[AW-1:0].
- next (combinational):
  - not jump: next = PC.
  - uncond: next = target.
  - cond: next = pred_taken ? target : PC.
- pred_taken = cond & i_valid & BHT[PC[IDX_W-1:0]][1].
- enable = cond & i_valid & ~stall.
- stall = cond & i_valid & full.
- BHT:
  - 2^IDX_W entries of 2-bit counters.
  - Reset value 2'b01 (weakly not-taken).
  - Read combinationally.
- Queue:
  - FIFO of {pc, target, pred}, depth 2^QD_W.
  - Read/write pointers QD_W+1 bits wide.
  - empty = (rd_ptr == wr_ptr); full = MSBs differ and lower bits equal.
  - Pointers wrap modulo 2^(QD_W+1).
  - Push on rising clk when enable=1.
- Resolve on rising clk when res_valid and ~empty:
  - Pop head.
  - Update BHT[head.pc[IDX_W-1:0]]: res_taken ? saturating +1 (max 3) : saturating -1 (min 0).
  - If res_taken != head.pred: mispredict <= 1; redirect <= res_taken ? head.target : head.pc; flush queue (rd_ptr <= wr_ptr after pop, discarding younger entries); any same-cycle push is dropped.
  - Otherwise mispredict <= 0.
- res_valid while empty: no pop, no BHT change, res_err <= 1 for one cycle.
- Simultaneous push and pop with no mispredict: both happen; occupancy unchanged. Allowed when full, since the pop frees a slot; stall is computed on pre-edge full and stays asserted that cycle (conservative).
- BHT write and same-cycle lookup at the same index: lookup sees the old value.
- Reset, at any time including mid-operation:
  - pointers 0
  - all BHT entries 01
  - mispredict = 0, redirect = 0, res_err = 0
  - queue contents don't-care

Optional Feature:
- Macro BPU_STATS_EN.
- When defined:
  - adds outputs stat_pred (16-bit) and stat_miss (16-bit).
  - stat_pred increments on each successful resolve; stat_miss on each mispredict.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package bpu_pkg:
  - opcode constants OPC_JMP = 3'b100, JUMP_BIT = 13
  - BHT_INIT = 2'b01
  - function sat_update(ctr, taken)
- One natural sub-module: bpu_queue, a parametrised FIFO with a flush input, instantiated once.

Test Plan:
- Reset, then I with I[13]=0, PC=11'h05 -> next=11'h05, enable=0, pred_taken=0.
- Uncond jump I[13:11]=100, I[10:0]=11'h123 -> next=11'h123, enable=0, no push.
- Conditional at PC=11'h010, target 11'h200, after reset -> enable=1, pred_taken=0, next=11'h010. Resolve taken -> mispredict pulse, redirect=11'h200, BHT[0]=10. Repeat -> pred_taken=1, next=11'h200.
- Push 4 conditional branches without resolve -> 5th asserts stall=1, enable=0. Resolve 1 correct -> stall clears next cycle.
- Queue holds 3 entries; resolve head mispredicted with a same-cycle push -> queue empty afterwards. A following res_valid -> res_err pulse, BHT unchanged.
- Assert rst mid-queue with BHT entry at 11 -> all outputs 0, empty, entry reads 01. With BPU_STATS_EN: 3 resolves (1 miss) -> stat_pred=3, stat_miss=1.
